lm_sm_sequencer: RTL and testbench
==================================

// Module: lm_sm_sequencer
// PURPOSE
//  Multi-cycle controller for IITB-RISC LM/SM (load/store multiple). Walks an 8-bit register mask,
//  one register per memory transfer: drives register file write port 1 (LM) or read port 2 (SM)
//  and the data-memory request/ack handshake. Sits beside the MEM stage; holds pipeline stall while busy.
// PARAMETERS
//  DATA_W      16  register/memory data width
//  ADDR_STEP   1   memory address increment per transferred register
//  TIMEOUT_CYC 15  max cycles waiting for mem_ack (used only with LMSM_ACK_TIMEOUT_EN)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle request from decode/MEM stage
//  is_load      in   1       1 = LM, 0 = SM; sampled with start
//  mask         in   8       bit i set -> transfer Ri; sampled with start
//  base_addr    in   DATA_W  first memory address; sampled with start
//  mem_req      out  1       memory request, held until mem_ack
//  mem_we       out  1       1 for SM transfers, 0 for LM; valid while mem_req
//  mem_addr     out  DATA_W  current transfer address
//  mem_wdata    out  DATA_W  = rf_rd_data (SM), 0 otherwise
//  mem_ack      in   1       transfer complete this cycle; mem_rdata valid if LM
//  mem_rdata    in   DATA_W  load data
//  rf_rd_addr   out  3       read port 2 address (SM current register)
//  rf_rd_data   in   DATA_W  combinational read data from register file
//  rf_we        out  1       write enable for register file port 1 (LM)
//  rf_waddr     out  3       write destination
//  rf_wdata     out  DATA_W  = mem_rdata
//  busy         out  1       sequencer not IDLE
//  stall        out  1       = busy | start; freezes upstream pipeline
//  done         out  1       1-cycle pulse at end of sequence
//  r7_written   out  1       pulses with rf_we when rf_waddr==7 (PC redirect hint)
//  err          out  1       sticky ack-timeout flag, cleared by next accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pending mask/address/timer cleared. Reset mid-sequence
//   aborts with no rf_we/mem_req in the reset cycle or after.
//  States: IDLE, XFER, DONE.
//  IDLE: start & mask!=0 -> latch is_load, mask, base_addr; next XFER.
//   start & mask==0 -> DONE (no transfers). start while not IDLE is ignored.
//  XFER: cur = index of lowest set bit in pending mask. mem_req=1, mem_addr = current addr,
//   mem_we = ~is_load, rf_rd_addr = cur. Outputs stable while mem_ack low.
//   On mem_ack: LM -> rf_we=1, rf_waddr=cur, rf_wdata=mem_rdata same cycle (combinational).
//   Clear bit cur, addr += ADDR_STEP (mod 2^DATA_W, wraps 0xFFFF->0x0000).
//   Pending becomes 0 -> DONE, else stay XFER; next request issues the following cycle (no bubble).
//  DONE: done=1 one cycle, busy=1; next IDLE. New start accepted only in IDLE.
//  Transfers = popcount(mask); sequence latency = transfers + ack waits + 2 cycles start->done.
//  mem_ack outside XFER is ignored.
// CONFIGURATION
//  LMSM_ACK_TIMEOUT_EN defined: counter resets each accepted ack/new request; reaching TIMEOUT_CYC
//   cycles without mem_ack in XFER -> drop mem_req, set err=1, go DONE (remaining bits skipped).
//  Not defined: XFER waits for mem_ack indefinitely; err tied 0; no counter logic.
// TESTING
//  LM mask=0x05 base=0x0010, ack every cycle -> rf_we to R0 @0x0010 then R2 @0x0011; done 1 cycle later.
//  SM mask=0x80 base=0xFFFF, rf_rd_data=0xBEEF, ack after 3 cycles -> mem_req held 3 cycles, mem_we=1, wdata=0xBEEF.
//  start mask=0x00 -> no mem_req, no rf_we, done pulses 2nd cycle, busy 1 cycle.
//  LM mask=0xFF base=0xFFFE -> 8 writes R0..R7, addresses wrap 0xFFFE,0xFFFF,0x0000..; r7_written on last.
//  rst asserted mid LM (after 2 of 4 transfers) -> next cycle IDLE, all outputs 0, no further rf_we.
//  With LMSM_ACK_TIMEOUT_EN, no ack for 15 cycles -> err=1, done pulse; new start clears err.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-cycle sequencer: walks an 8-bit register mask, one memory transfer per register.
// Optional ack timeout is enabled by defining LMSM_ACK_TIMEOUT_EN.
module lm_sm_sequencer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_STEP   = 1,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [7:0]        mask,
    input  logic [DATA_W-1:0] base_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic              r7_written,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic [7:0]        pend_q, pend_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [2:0]        cur;
    logic              active;
    logic              timeout;

    // Lowest set bit of the pending mask selects the register for this transfer.
    always_comb begin
        cur = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) cur = 3'(i);
        end
    end

`ifdef LMSM_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q;
    logic          err_q;

    assign timeout = (state_q == XFER) && !mem_ack && (timer_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= (state_q == XFER && !mem_ack && !timeout) ? timer_q + 1'b1 : '0;
            if (state_q == IDLE && start) err_q <= 1'b0;
            else if (timeout)             err_q <= 1'b1;
        end
    end

    assign err = err_q && !rst;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0);
    assign timeout    = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load_d  = is_load;
                    pend_d  = mask;
                    addr_d  = base_addr;
                    state_d = (mask != 8'h00) ? XFER : DONE;
                end
            end
            XFER: begin
                if (mem_ack) begin
                    pend_d = pend_q & ~(8'b1 << cur);
                    addr_d = addr_q + DATA_W'(ADDR_STEP);
                    if (pend_d == 8'h00) state_d = DONE;
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            pend_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
        end
    end

    // NOTE: reset is synchronous, so outputs are gated by rst to stay quiet during the reset cycle itself.
    assign active     = (state_q == XFER) && !rst;
    assign mem_req    = active;
    assign mem_we     = active && !load_q;
    assign mem_addr   = active ? addr_q : '0;
    assign mem_wdata  = (active && !load_q) ? rf_rd_data : '0;
    assign rf_rd_addr = active ? cur : '0;
    assign rf_we      = active && load_q && mem_ack;
    assign rf_waddr   = active ? cur : '0;
    assign rf_wdata   = rf_we ? mem_rdata : '0;
    assign r7_written = rf_we && (cur == 3'd7);
    assign busy       = (state_q != IDLE) && !rst;
    assign done       = (state_q == DONE) && !rst;
    assign stall      = busy || start;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer; timeout scenario follows LMSM_ACK_TIMEOUT_EN.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, is_load, mem_ack;
    logic [7:0]  mask;
    logic [15:0] base_addr, mem_rdata, rf_rd_data;
    logic        mem_req, mem_we, rf_we, busy, stall, done, r7_written, err;
    logic [15:0] mem_addr, mem_wdata, rf_wdata;
    logic [2:0]  rf_rd_addr, rf_waddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lm_sm_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .mask(mask),
        .base_addr(base_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .stall(stall),
        .done(done), .r7_written(r7_written), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_load = 1'b0; mask = '0; base_addr = '0;
        mem_ack = 1'b0; mem_rdata = '0; rf_rd_data = 16'h5A5A;
        tick(); tick(); #2;
        checks++;
        if ({mem_req, mem_we, rf_we, busy, stall, done, r7_written, err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 00000000",
                     {mem_req, mem_we, rf_we, busy, stall, done, r7_written, err});
        end
        checks++;
        if ({mem_addr, mem_wdata, rf_wdata} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, rf_wdata});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lm_basic();
        start = 1'b1; is_load = 1'b1; mask = 8'h05; base_addr = 16'h0010;
        mem_ack = 1'b1; mem_rdata = 16'h1111; #2;
        checks++;
        if ({stall, busy, mem_req, rf_we, done} !== 5'b10000) begin
            errors++; $display("FAIL lm_start got %b exp 10000", {stall, busy, mem_req, rf_we, done});
        end
        tick(); start = 1'b0; mask = '0; #2;
        checks++;
        if ({mem_req, mem_we, rf_we, busy, done, mem_addr, rf_waddr, rf_wdata} !==
            {5'b10110, 16'h0010, 3'd0, 16'h1111}) begin
            errors++; $display("FAIL lm_xfer0 got %b %h %0d %h exp 10110 0010 0 1111",
                               {mem_req, mem_we, rf_we, busy, done}, mem_addr, rf_waddr, rf_wdata);
        end
        tick(); mem_rdata = 16'h2222; #2;
        checks++;
        if ({rf_we, mem_addr, rf_waddr, rf_wdata, r7_written} !== {1'b1, 16'h0011, 3'd2, 16'h2222, 1'b0}) begin
            errors++; $display("FAIL lm_xfer1 got %b %h %0d %h exp 1 0011 2 2222",
                               rf_we, mem_addr, rf_waddr, rf_wdata);
        end
        tick(); #2;
        checks++;
        if ({mem_req, rf_we, busy, done} !== 4'b0011) begin
            errors++; $display("FAIL lm_done got %b exp 0011", {mem_req, rf_we, busy, done});
        end
        tick(); #2;
        checks++;
        if ({busy, done, stall, rf_we} !== 4'b0000) begin
            errors++; $display("FAIL lm_idle got %b exp 0000", {busy, done, stall, rf_we});
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_sm_wait();
        rf_rd_data = 16'hBEEF;
        start = 1'b1; is_load = 1'b0; mask = 8'h80; base_addr = 16'hFFFF; mem_ack = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            start = (c == 1); is_load = (c == 1); mask = (c == 1) ? 8'h01 : 8'h00;
            mem_ack = (c == 2); #2;
            checks++;
            if ({mem_req, mem_we, rf_we, busy, mem_addr, rf_rd_addr, mem_wdata} !==
                {4'b1101, 16'hFFFF, 3'd7, 16'hBEEF}) begin
                errors++; $display("FAIL sm_wait%0d got %b %h %0d %h exp 1101 ffff 7 beef", c,
                                   {mem_req, mem_we, rf_we, busy}, mem_addr, rf_rd_addr, mem_wdata);
            end
            tick();
        end
        start = 1'b0; is_load = 1'b0; mem_ack = 1'b0; #2;
        checks++;
        if ({done, mem_req, mem_we, mem_wdata} !== {3'b100, 16'h0}) begin
            errors++; $display("FAIL sm_done got %b %h exp 100 0000", {done, mem_req, mem_we}, mem_wdata);
        end
        tick(); #2;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL sm_idle got %b exp 00", {busy, done});
        end
    endtask

    task automatic test_empty_mask();
        start = 1'b1; is_load = 1'b1; mask = 8'h00; base_addr = 16'h0040; mem_ack = 1'b1; #2;
        checks++;
        if ({stall, busy, done} !== 3'b100) begin
            errors++; $display("FAIL empty_start got %b exp 100", {stall, busy, done});
        end
        tick(); start = 1'b0; #2;
        checks++;
        if ({mem_req, rf_we, busy, done} !== 4'b0011) begin
            errors++; $display("FAIL empty_done got %b exp 0011", {mem_req, rf_we, busy, done});
        end
        tick(); #2;
        checks++;
        if ({mem_req, rf_we, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL empty_idle got %b exp 0000", {mem_req, rf_we, busy, done});
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_wrap_all();
        logic [15:0] exp_addr;
        start = 1'b1; is_load = 1'b1; mask = 8'hFF; base_addr = 16'hFFFE; mem_ack = 1'b1;
        tick(); start = 1'b0;
        exp_addr = 16'hFFFE;
        for (int i = 0; i < 8; i++) begin
            mem_rdata = 16'hA000 | 16'(i); #2;
            checks++;
            if ({rf_we, rf_waddr, mem_addr, rf_wdata, r7_written} !==
                {1'b1, 3'(i), exp_addr, 16'hA000 | 16'(i), (i == 7)}) begin
                errors++; $display("FAIL wrap%0d got we=%b r%0d @%h %h r7=%b exp r%0d @%h", i,
                                   rf_we, rf_waddr, mem_addr, rf_wdata, r7_written, i, exp_addr);
            end
            exp_addr = exp_addr + 16'd1;
            tick();
        end
        #2;
        checks++;
        if ({done, rf_we, r7_written} !== 3'b100) begin
            errors++; $display("FAIL wrap_done got %b exp 100", {done, rf_we, r7_written});
        end
        tick(); mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; is_load = 1'b1; mask = 8'h0F; base_addr = 16'h0100; mem_ack = 1'b1;
        mem_rdata = 16'h7777;
        tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if ({rf_we, rf_waddr} !== {1'b1, 3'(i)}) begin
                errors++; $display("FAIL rmid_xfer%0d got %b r%0d exp 1 r%0d", i, rf_we, rf_waddr, i);
            end
            tick();
        end
        rst = 1'b1; #2;
        checks++;
        if ({mem_req, rf_we, busy, done, stall} !== 5'b0) begin
            errors++; $display("FAIL rmid_rstcyc got %b exp 00000", {mem_req, rf_we, busy, done, stall});
        end
        tick(); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if ({mem_req, rf_we, busy, done, rf_wdata} !== {4'b0000, 16'h0}) begin
                errors++; $display("FAIL rmid_after%0d got %b %h exp 0000 0000", i,
                                   {mem_req, rf_we, busy, done}, rf_wdata);
            end
            tick();
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_ack_wait();
        start = 1'b1; is_load = 1'b0; mask = 8'h01; base_addr = 16'h1234; mem_ack = 1'b0;
        tick(); start = 1'b0;
`ifdef LMSM_ACK_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            #2;
            checks++;
            if ({mem_req, err, done} !== 3'b100) begin
                errors++; $display("FAIL to_wait%0d got %b exp 100", i, {mem_req, err, done});
            end
            tick();
        end
        #2;
        checks++;
        if ({mem_req, err, done} !== 3'b011) begin
            errors++; $display("FAIL to_done got %b exp 011", {mem_req, err, done});
        end
        tick(); #2;
        checks++;
        if ({busy, err} !== 2'b01) begin
            errors++; $display("FAIL to_sticky got %b exp 01", {busy, err});
        end
        start = 1'b1; mask = 8'h00;
        tick(); start = 1'b0; #2;
        checks++;
        if ({done, err} !== 2'b10) begin
            errors++; $display("FAIL to_clear got %b exp 10", {done, err});
        end
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            #2;
            checks++;
            if ({mem_req, mem_we, err, done} !== 4'b1100) begin
                errors++; $display("FAIL wait%0d got %b exp 1100", i, {mem_req, mem_we, err, done});
            end
            tick();
        end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; #2;
        checks++;
        if ({mem_req, err, done} !== 3'b001) begin
            errors++; $display("FAIL wait_done got %b exp 001", {mem_req, err, done});
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_lm_basic();
        test_sm_wait();
        test_empty_mask();
        test_wrap_all();
        test_reset_mid();
        test_ack_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
